// File: rtl/vga_pkg.sv
// Shared types and the default 1024x768@60 raster timing.
package vga_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef logic [10:0] hcount_t;
    typedef logic [9:0]  vcount_t;

    localparam int   XVGA_H_ACTIVE = 1024;
    localparam int   XVGA_H_FP     = 24;
    localparam int   XVGA_H_SYNC   = 136;
    localparam int   XVGA_H_BP     = 160;
    localparam int   XVGA_V_ACTIVE = 768;
    localparam int   XVGA_V_FP     = 3;
    localparam int   XVGA_V_SYNC   = 6;
    localparam int   XVGA_V_BP     = 29;
    localparam logic XVGA_HS_POL   = 1'b0;
    localparam logic XVGA_VS_POL   = 1'b0;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register that realigns control bits with late pixel data.
// DEPTH=0 degenerates to a plain wire.
module sync_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stages [DEPTH];

            // Shift one stage per clock; reset fills every stage with RST_VAL.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stages[i] <= RST_VAL;
                end else begin
                    stages[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
                end
            end

            assign q = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/xvga_timing_gen.sv
// Raster counter / sync generator for the pixel interface. The counters go to the
// game logic; the VGA pins are delayed so syncs line up with the returned pixels.
module xvga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = XVGA_H_ACTIVE,
    parameter int   H_FP     = XVGA_H_FP,
    parameter int   H_SYNC   = XVGA_H_SYNC,
    parameter int   H_BP     = XVGA_H_BP,
    parameter int   V_ACTIVE = XVGA_V_ACTIVE,
    parameter int   V_FP     = XVGA_V_FP,
    parameter int   V_SYNC   = XVGA_V_SYNC,
    parameter int   V_BP     = XVGA_V_BP,
    parameter logic HS_POL   = XVGA_HS_POL,
    parameter logic VS_POL   = XVGA_VS_POL,
    parameter int   PIX_LAT  = 2
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        blank_out,
    output logic        frame_done_out,
    input  logic [11:0] pixel_in,
    output logic [3:0]  vga_r_out,
    output logic [3:0]  vga_g_out,
    output logic [3:0]  vga_b_out,
    output logic        vga_hs_out,
    output logic        vga_vs_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // All raster compares are done at 32 bits so no parameter is truncated.
    localparam logic [31:0] H_LAST     = 32'(H_TOTAL - 1);
    localparam logic [31:0] V_LAST     = 32'(V_TOTAL - 1);
    localparam logic [31:0] H_ACT_W    = 32'(H_ACTIVE);
    localparam logic [31:0] V_ACT_W    = 32'(V_ACTIVE);
    localparam logic [31:0] HS_START   = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END     = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_START   = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END     = 32'(V_ACTIVE + V_FP + V_SYNC);

    logic [31:0] h_wide;
    logic [31:0] v_wide;
    logic        h_last;
    logic        v_last;
    logic        hs_level;
    logic        vs_level;
    logic        blank_dly;
    logic        hs_dly;
    logic        vs_dly;
    rgb12_t      pixel;

    assign h_wide = 32'(hcount_out);
    assign v_wide = 32'(vcount_out);
    assign h_last = (h_wide == H_LAST);
    assign v_last = (v_wide == V_LAST);

    // Raster counters: column every cycle, line on column wrap.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            hcount_out <= '0;
            vcount_out <= '0;
        end else if (h_last) begin
            hcount_out <= '0;
            vcount_out <= v_last ? '0 : vcount_out + 10'd1;
        end else begin
            hcount_out <= hcount_out + 11'd1;
        end
    end

    // Decodes straight off the registered counters; vsync only moves at column 0.
    assign blank_out      = (h_wide >= H_ACT_W) || (v_wide >= V_ACT_W);
    assign frame_done_out = (h_wide == H_ACT_W) && (v_wide == V_ACT_W);
    assign hs_level       = ((h_wide >= HS_START) && (h_wide < HS_END)) ? HS_POL : ~HS_POL;
    assign vs_level       = ((v_wide >= VS_START) && (v_wide < VS_END)) ? VS_POL : ~VS_POL;

    sync_delay #(
        .WIDTH   (3),
        .DEPTH   (PIX_LAT),
        .RST_VAL ({1'b1, ~HS_POL, ~VS_POL})
    ) u_align (
        .clk (pixel_clk_in),
        .rst (rst_in),
        .d   ({blank_out, hs_level, vs_level}),
        .q   ({blank_dly, hs_dly, vs_dly})
    );

    assign pixel = pixel_in;

    // Pin register: pixel data is forced dark whenever the aligned blank is set.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            vga_r_out  <= '0;
            vga_g_out  <= '0;
            vga_b_out  <= '0;
            vga_hs_out <= ~HS_POL;
            vga_vs_out <= ~VS_POL;
        end else begin
            vga_r_out  <= blank_dly ? 4'h0 : pixel.r;
            vga_g_out  <= blank_dly ? 4'h0 : pixel.g;
            vga_b_out  <= blank_dly ? 4'h0 : pixel.b;
            vga_hs_out <= hs_dly;
            vga_vs_out <= vs_dly;
        end
    end

endmodule

// File: tb/tb_xvga_timing_gen.sv
// Bench for xvga_timing_gen: two reduced-size rasters (PIX_LAT=2 and PIX_LAT=0,
// the latter with positive sync polarity) plus one full 1024x768 instance, all
// compared every cycle against a position-arithmetic model.
module tb_xvga_timing_gen;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        bit hpol, vpol;
        int lat;
    } tcfg_t;

    typedef struct {
        int          h, v;
        bit          blank, fd;
        logic [11:0] rgb;
        bit          hs, vs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [11:0] pixel_in;

    logic [10:0] h_a, h_b, h_c;
    logic [9:0]  v_a, v_b, v_c;
    logic        bl_a, bl_b, bl_c, fd_a, fd_b, fd_c;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic        hs_a, vs_a, hs_b, vs_b, hs_c, vs_c;

    int          checks = 0;
    int          errors = 0;
    int          k      = 0;
    logic [11:0] pix_hist [0:4095];
    int          lit_a, lit_b, fdcnt_a;
    tcfg_t       cfg_a, cfg_b, cfg_c;

    always #5 clk = ~clk;

    xvga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(2)
    ) u_dut_a (
        .pixel_clk_in(clk), .rst_in(rst_in),
        .hcount_out(h_a), .vcount_out(v_a), .blank_out(bl_a), .frame_done_out(fd_a),
        .pixel_in(pixel_in),
        .vga_r_out(r_a), .vga_g_out(g_a), .vga_b_out(b_a),
        .vga_hs_out(hs_a), .vga_vs_out(vs_a)
    );

    xvga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(0)
    ) u_dut_b (
        .pixel_clk_in(clk), .rst_in(rst_in),
        .hcount_out(h_b), .vcount_out(v_b), .blank_out(bl_b), .frame_done_out(fd_b),
        .pixel_in(pixel_in),
        .vga_r_out(r_b), .vga_g_out(g_b), .vga_b_out(b_b),
        .vga_hs_out(hs_b), .vga_vs_out(vs_b)
    );

    xvga_timing_gen u_dut_c (
        .pixel_clk_in(clk), .rst_in(rst_in),
        .hcount_out(h_c), .vcount_out(v_c), .blank_out(bl_c), .frame_done_out(fd_c),
        .pixel_in(pixel_in),
        .vga_r_out(r_c), .vga_g_out(g_c), .vga_b_out(b_c),
        .vga_hs_out(hs_c), .vga_vs_out(vs_c)
    );

    // Expected state n cycles after reset release: position is n mod line/frame length,
    // pins show the position issued lat+1 cycles earlier, dark/inactive before that.
    function automatic exp_t model(tcfg_t c, int n, logic [11:0] pix);
        exp_t e;
        int   ht, vt, idx, ph, pv;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        e.h     = n % ht;
        e.v     = (n / ht) % vt;
        e.blank = (e.h >= c.ha) || (e.v >= c.va);
        e.fd    = (e.h == c.ha) && (e.v == c.va);
        idx = n - 1 - c.lat;
        if (idx < 0) begin
            e.rgb = 12'h000;
            e.hs  = ~c.hpol;
            e.vs  = ~c.vpol;
        end else begin
            ph = idx % ht;
            pv = (idx / ht) % vt;
            e.rgb = ((ph >= c.ha) || (pv >= c.va)) ? 12'h000 : pix;
            e.hs  = (ph >= c.ha + c.hf && ph < c.ha + c.hf + c.hs) ? c.hpol : ~c.hpol;
            e.vs  = (pv >= c.va + c.vf && pv < c.va + c.vf + c.vs) ? c.vpol : ~c.vpol;
        end
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s k=%0d: observed %0h expected %0h", tag, k, observed, expected);
        end
    endtask

    task automatic check_dut(string name, tcfg_t c, int n,
                             logic [10:0] h, logic [9:0] v, logic bl, logic fd,
                             logic [3:0] r, logic [3:0] g, logic [3:0] b,
                             logic hs, logic vs);
        exp_t e;
        e = model(c, n, (n > 0) ? pix_hist[n] : 12'h000);
        chk({name, ".hcount"}, 32'(h),  32'(e.h));
        chk({name, ".vcount"}, 32'(v),  32'(e.v));
        chk({name, ".blank"},  32'(bl), 32'(e.blank));
        chk({name, ".frame_done"}, 32'(fd), 32'(e.fd));
        chk({name, ".rgb"},    32'({r, g, b}), 32'(e.rgb));
        chk({name, ".hs"},     32'(hs), 32'(e.hs));
        chk({name, ".vs"},     32'(vs), 32'(e.vs));
    endtask

    task automatic check_all(int n);
        check_dut("a", cfg_a, n, h_a, v_a, bl_a, fd_a, r_a, g_a, b_a, hs_a, vs_a);
        check_dut("b", cfg_b, n, h_b, v_b, bl_b, fd_b, r_b, g_b, b_b, hs_b, vs_b);
        check_dut("c", cfg_c, n, h_c, v_c, bl_c, fd_c, r_c, g_c, b_c, hs_c, vs_c);
    endtask

    task automatic run(int ncyc, bit white);
        logic [11:0] pix;
        for (int i = 0; i < ncyc; i++) begin
            pix = white ? 12'hFFF : 12'($urandom);
            pixel_in = pix;
            pix_hist[k + 1] = pix;
            @(negedge clk);
            k++;
            check_all(k);
            if (fd_a === 1'b1) fdcnt_a++;
            if (k >= 3 && k < 3 + 325 && {r_a, g_a, b_a} === 12'hFFF) lit_a++;
            if (k >= 1 && k < 1 + 325 && {r_b, g_b, b_b} === 12'hFFF) lit_b++;
        end
    endtask

    initial begin
        cfg_a = '{ha:16, hf:2, hs:3, hb:4, va:8, vf:1, vs:2, vb:2, hpol:1'b0, vpol:1'b0, lat:2};
        cfg_b = '{ha:16, hf:2, hs:3, hb:4, va:8, vf:1, vs:2, vb:2, hpol:1'b1, vpol:1'b1, lat:0};
        cfg_c = '{ha:1024, hf:24, hs:136, hb:160, va:768, vf:3, vs:6, vb:29,
                  hpol:1'b0, vpol:1'b0, lat:2};

        rst_in   = 1'b1;
        pixel_in = 12'h000;
        repeat (5) @(posedge clk);
        @(negedge clk);
        k = 0;
        check_all(0);
        rst_in = 1'b0;

        // Random pixel data up to the mid-line point (10,5) of the small raster.
        fdcnt_a = 0;
        run(2 * 325 + 5 * 25 + 10, 1'b0);
        chk("a.frame_done_count", 32'(fdcnt_a), 32'd2);

        // Asynchronous reset between clock edges.
        #1 rst_in = 1'b1;
        #1 k = 0;
        check_all(0);
        repeat (3) begin
            @(negedge clk);
            check_all(0);
        end
        rst_in = 1'b0;

        // Constant white: lit pixels only inside the active window, long enough
        // for the full-size instance to complete its first hsync.
        lit_a = 0;
        lit_b = 0;
        run(1400, 1'b1);
        chk("a.lit_pixels_per_frame", 32'(lit_a), 32'd128);
        chk("b.lit_pixels_per_frame", 32'(lit_b), 32'd128);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
